lms_adaptive_fir: RTL and testbench

- Self-contained 4-tap LMS system-identification block in signed Q4.12 fixed point.
- An internal fixed-coefficient 4-tap FIR acts as the unknown plant and produces the desired signal d from x_in.
- A 4-tap adaptive FIR driven by the same x_in produces y_out. It updates its weights every clock so that y_out tracks d.
- Used as a standalone adaptive-filter demonstrator; weights, output and error are exported for monitoring.

---
 rtl/lms_adaptive_fir.sv | 115 +++++++++++
 tb/tb_lms_adaptive_fir.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lms_adaptive_fir.sv
// ---------------------------------------------------------------------------
// lms_adaptive_fir
//   4-tap LMS system-identification demonstrator in signed Q4.12.
//   A fixed 4-tap FIR (H0..H3) is the "unknown" plant producing d from the
//   shared tap delay line; a 4-tap adaptive FIR on the same taps produces
//   y_out, and its weights are nudged every clock by mu*err*x (mu = 2^-MU_SHIFT)
//   so that y_out tracks d.  All 16-bit results saturate, nothing wraps.
//
// Ports
//   Clk    in   system clock, rising edge
//   Rst    in   asynchronous active-high reset (clears taps and weights)
//   x_in   in   Q4.12 input sample, captured every rising edge
//   w0..w3 out  adaptive weights, Q4.12
//   y_out  out  adaptive filter output, Q4.12 (combinational from registers)
//   err    out  d - y_out, Q4.12 (combinational from registers)
// ---------------------------------------------------------------------------
module lms_adaptive_fir #(
    parameter int DATA_W   = 16,
    parameter int FRAC     = 12,
    parameter int MU_SHIFT = 4,
    parameter int H0       = 2048,
    parameter int H1       = 1024,
    parameter int H2       = -512,
    parameter int H3       = 256
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [DATA_W-1:0] x_in,
    output logic [DATA_W-1:0] w0,
    output logic [DATA_W-1:0] w1,
    output logic [DATA_W-1:0] w2,
    output logic [DATA_W-1:0] w3,
    output logic [DATA_W-1:0] y_out,
    output logic [DATA_W-1:0] err
);

    localparam int PROD_W = 2 * DATA_W;
    // Four full products summed need two guard bits beyond the product width.
    localparam int ACC_W  = 2 * DATA_W + 2;
    localparam int UPD_SH = FRAC + MU_SHIFT;

    localparam logic signed [DATA_W-1:0] HK [4] = '{
        DATA_W'(H0), DATA_W'(H1), DATA_W'(H2), DATA_W'(H3)
    };

    // Clamp a wide signed value into the DATA_W signed range.
    function automatic logic signed [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] vmax;
        logic signed [ACC_W-1:0] vmin;
        vmax = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
        vmin = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
        if (v > vmax)      return {1'b0, {(DATA_W-1){1'b1}}};
        else if (v < vmin) return {1'b1, {(DATA_W-1){1'b0}}};
        else               return v[DATA_W-1:0];
    endfunction

    logic signed [DATA_W-1:0] taps  [4];
    logic signed [DATA_W-1:0] wts   [4];
    logic signed [DATA_W-1:0] w_nxt [4];

    logic signed [PROD_W-1:0] d_prod   [4];
    logic signed [PROD_W-1:0] y_prod   [4];
    logic signed [PROD_W-1:0] upd_prod [4];
    logic signed [ACC_W-1:0]  w_sum    [4];
    logic signed [ACC_W-1:0]  d_acc;
    logic signed [ACC_W-1:0]  y_acc;
    logic signed [DATA_W-1:0] d;
    logic signed [DATA_W-1:0] y_s;
    logic signed [DATA_W:0]   e_diff;
    logic signed [DATA_W-1:0] err_s;

    // Plant, adaptive filter, error and next weights -- all from the current
    // register contents, so reset forces every output to zero at once.
    always_comb begin
        d_acc = '0;
        y_acc = '0;
        for (int k = 0; k < 4; k++) begin
            d_prod[k] = HK[k] * taps[k];
            y_prod[k] = wts[k] * taps[k];
            d_acc     = d_acc + ACC_W'(d_prod[k]);
            y_acc     = y_acc + ACC_W'(y_prod[k]);
        end
        d      = sat(d_acc >>> FRAC);
        y_s    = sat(y_acc >>> FRAC);
        // 17-bit difference cannot overflow; only the clamp to 16 bits remains.
        e_diff = {d[DATA_W-1], d} - {y_s[DATA_W-1], y_s};
        err_s  = sat(ACC_W'(e_diff));
        for (int k = 0; k < 4; k++) begin
            upd_prod[k] = err_s * taps[k];
            // mu*err*x in one arithmetic shift: FRAC rescales, MU_SHIFT is mu.
            w_sum[k]    = ACC_W'(wts[k]) + ACC_W'(upd_prod[k] >>> UPD_SH);
            w_nxt[k]    = sat(w_sum[k]);
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            taps <= '{default: '0};
            wts  <= '{default: '0};
        end else begin
            taps[0] <= x_in;
            for (int k = 1; k < 4; k++) taps[k] <= taps[k-1];
            // Uses pre-edge err and taps, landing together with the shift.
            wts <= w_nxt;
        end
    end

    assign w0    = wts[0];
    assign w1    = wts[1];
    assign w2    = wts[2];
    assign w3    = wts[3];
    assign y_out = y_s;
    assign err   = err_s;

endmodule

// File: tb/tb_lms_adaptive_fir.sv
// ---------------------------------------------------------------------------
// tb_lms_adaptive_fir
//   Scoreboard bench: every stimulus cycle advances a behavioural model of
//   the LMS loop and queues the expected post-edge outputs; a monitor pops
//   and compares after each rising edge.  Two instances run side by side:
//   u_dut with the default plant, u_sat with a 2.0-per-tap plant that drives
//   every stage into saturation.
// ---------------------------------------------------------------------------
module tb_lms_adaptive_fir;

    typedef struct packed {
        int w0; int w1; int w2; int w3; int y; int e;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [15:0] x_a, x_b;
    logic [15:0] aw [4];
    logic [15:0] bw [4];
    logic [15:0] ay, ae, by, be;

    lms_adaptive_fir u_dut (
        .Clk(Clk), .Rst(Rst), .x_in(x_a),
        .w0(aw[0]), .w1(aw[1]), .w2(aw[2]), .w3(aw[3]),
        .y_out(ay), .err(ae)
    );

    lms_adaptive_fir #(.H0(8192), .H1(8192), .H2(8192), .H3(8192)) u_sat (
        .Clk(Clk), .Rst(Rst), .x_in(x_b),
        .w0(bw[0]), .w1(bw[1]), .w2(bw[2]), .w3(bw[3]),
        .y_out(by), .err(be)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    function automatic void check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endfunction

    function automatic void check_range(string name, int act, int lo, int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s actual=%0d required=[%0d,%0d]", name, act, lo, hi);
        end
    endfunction

    function automatic int s16(logic [15:0] v);
        return int'($signed(v));
    endfunction

    // ---------------- behavioural model (index 0 = u_dut, 1 = u_sat) -------
    int mh [2][4] = '{'{2048, 1024, -512, 256}, '{8192, 8192, 8192, 8192}};
    int mx [2][4];
    int mw [2][4];

    function automatic int sat16(longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    // Weighted tap sum with Q4.12 rescale; floor division by 4096.
    function automatic int m_fir(int i, bit adaptive);
        longint s = 0;
        for (int k = 0; k < 4; k++)
            s += longint'(adaptive ? mw[i][k] : mh[i][k]) * longint'(mx[i][k]);
        return sat16(s >>> 12);
    endfunction

    function automatic int m_err(int i);
        return sat16(longint'(m_fir(i, 1'b0)) - longint'(m_fir(i, 1'b1)));
    endfunction

    function automatic void m_clock(int i, int xs, bit r);
        int e;
        if (r) begin
            for (int k = 0; k < 4; k++) begin mx[i][k] = 0; mw[i][k] = 0; end
            return;
        end
        e = m_err(i);
        for (int k = 0; k < 4; k++)
            mw[i][k] = sat16(longint'(mw[i][k]) + ((longint'(e) * longint'(mx[i][k])) >>> 16));
        for (int k = 3; k > 0; k--) mx[i][k] = mx[i][k-1];
        mx[i][0] = xs;
    endfunction

    function automatic exp_t m_snap(int i);
        exp_t s;
        s.w0 = mw[i][0]; s.w1 = mw[i][1]; s.w2 = mw[i][2]; s.w3 = mw[i][3];
        s.y  = m_fir(i, 1'b1);
        s.e  = m_err(i);
        return s;
    endfunction

    exp_t qa[$];
    exp_t qb[$];

    // ---------------- monitor ----------------------------------------------
    function automatic void cmp(string tag, int w0, int w1, int w2, int w3,
                                int y, int e, exp_t x);
        check({tag, ".w0"}, w0, x.w0);
        check({tag, ".w1"}, w1, x.w1);
        check({tag, ".w2"}, w2, x.w2);
        check({tag, ".w3"}, w3, x.w3);
        check({tag, ".y"},  y,  x.y);
        check({tag, ".err"}, e, x.e);
    endfunction

    always @(posedge Clk) begin
        exp_t ea, eb;
        #1;
        if (qa.size() > 0) begin
            ea = qa.pop_front();
            cmp("sb.dut", s16(aw[0]), s16(aw[1]), s16(aw[2]), s16(aw[3]), s16(ay), s16(ae), ea);
        end
        if (qb.size() > 0) begin
            eb = qb.pop_front();
            cmp("sb.sat", s16(bw[0]), s16(bw[1]), s16(bw[2]), s16(bw[3]), s16(by), s16(be), eb);
        end
    end

    // ---------------- stimulus ---------------------------------------------
    function automatic void drive(int xa, int xb, bit r);
        x_a = xa[15:0];
        x_b = xb[15:0];
        Rst = r;
        m_clock(0, xa, r);
        m_clock(1, xb, r);
        qa.push_back(m_snap(0));
        qb.push_back(m_snap(1));
    endfunction

    task automatic step(int xa, int xb, bit r);
        @(negedge Clk);
        drive(xa, xb, r);
        @(posedge Clk);
        #2;
    endtask

    function automatic void chk_zero(string tag);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s.dut.w%0d", tag, k), s16(aw[k]), 0);
            check($sformatf("%s.sat.w%0d", tag, k), s16(bw[k]), 0);
        end
        check({tag, ".dut.y"},   s16(ay), 0);
        check({tag, ".dut.err"}, s16(ae), 0);
        check({tag, ".sat.y"},   s16(by), 0);
        check({tag, ".sat.err"}, s16(be), 0);
    endfunction

    // Impulse response of the adaptation from zero state: err walks the plant
    // taps, and each weight picks up err*4096 >> 16 one edge later.
    int imp_err [5]    = '{2048, 1024, -512, 256, 0};
    int imp_w   [5][4] = '{'{0, 0, 0, 0}, '{128, 0, 0, 0}, '{128, 64, 0, 0},
                           '{128, 64, -32, 0}, '{128, 64, -32, 16}};

    task automatic impulse(string tag);
        for (int n = 0; n < 5; n++) begin
            step((n == 0) ? 4096 : 0, 0, 1'b0);
            check($sformatf("%s.e%0d.y", tag, n + 1),   s16(ay), 0);
            check($sformatf("%s.e%0d.err", tag, n + 1), s16(ae), imp_err[n]);
            for (int k = 0; k < 4; k++)
                check($sformatf("%s.e%0d.w%0d", tag, n + 1, k), s16(aw[k]), imp_w[n][k]);
        end
    endtask

    int rnd [128];
    int ha  [4] = '{2048, 1024, -512, 256};

    initial begin
        int wsum;
        Rst = 1'b0;
        x_a = 16'd1234;
        x_b = 16'd1234;
        #1 Rst = 1'b1;
        #1 chk_zero("rst.async");
        step(1234, 1234, 1'b1);
        step(1234, 1234, 1'b1);
        chk_zero("rst.hold");

        // Release between edges: nothing changes until the next rising edge.
        @(negedge Clk);
        drive(0, 0, 1'b0);
        #1 chk_zero("rst.release");
        @(posedge Clk);
        #2;

        impulse("imp1");

        // Constant input; u_sat sees full-scale so d pins at +32767 and
        // err can only be non-negative.
        for (int n = 0; n < 300; n++) begin
            step(4096, 32767, 1'b0);
            check_range("sat.err_nonneg", s16(be), 0, 32767);
        end
        // With all taps at 1.0, y equals the weight sum and the truncating
        // update stops moving once err drops below 16 LSB.
        wsum = s16(aw[0]) + s16(aw[1]) + s16(aw[2]) + s16(aw[3]);
        check_range("const.err", s16(ae), 0, 15);
        check("const.sum_plus_err", wsum + s16(ae), 2816);
        check_range("const.sum", wsum, 2816 - 15, 2816);

        for (int i = 0; i < 128; i++) rnd[i] = int'($urandom_range(8191)) - 4096;

        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 128; i++)
                step(rnd[i], int'($urandom_range(65535)) - 32768, 1'b0);

        // Reset pulse between edges, then replay the impulse from scratch.
        @(negedge Clk);
        #2;
        x_a = 16'd0;
        x_b = 16'd0;
        Rst = 1'b1;
        m_clock(0, 0, 1'b1);
        m_clock(1, 0, 1'b1);
        #1 chk_zero("midrst");
        #1 Rst = 1'b0;
        qa.push_back(m_snap(0));
        qb.push_back(m_snap(1));
        @(posedge Clk);
        #2;
        impulse("imp2");

        for (int r = 0; r < 5; r++)
            for (int i = 0; i < 128; i++)
                step(rnd[i], int'($urandom_range(65535)) - 32768, 1'b0);

        // Floor truncation of small updates biases weights slightly low, so
        // convergence is checked with a band wider than the raw update LSB.
        for (int k = 0; k < 4; k++)
            check_range($sformatf("conv.w%0d", k), s16(aw[k]), ha[k] - 64, ha[k] + 64);
        check_range("conv.err", s16(ae), -160, 160);

        @(posedge Clk);
        #2;
        check("sb.drained", qa.size() + qb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
